// File: rtl/anim_if.sv
// Button pulses into the animation sequencer and the registered state it reports back.
// Pulses are single-cycle strobes sampled on the rising clock edge; no handshake back-pressure exists.
interface anim_if;
    logic       mode_pulse;
    logic       speed_pulse;
    logic       pause_pulse;
    logic [1:0] mode;
    logic [3:0] frame_idx;
    logic [1:0] speed;
    logic       paused;
    logic       blank;
    logic       frame_tick;
    logic       cycle_done;

    modport master (
        output mode_pulse, speed_pulse, pause_pulse,
        input  mode, frame_idx, speed, paused, blank, frame_tick, cycle_done
    );

    modport slave (
        input  mode_pulse, speed_pulse, pause_pulse,
        output mode, frame_idx, speed, paused, blank, frame_tick, cycle_done
    );
endinterface

// File: rtl/anim_sequencer.sv
// Turns button pulses into animation mode/speed/pause state and steps the frame index
// from a prescaled frame tick, blanking the display for a few ticks after each mode change.
module anim_sequencer #(
    parameter int unsigned BASE_DIV    = 2_500_000,
    parameter int unsigned BLANK_TICKS = 2,
    parameter int unsigned LEN0        = 6,
    parameter int unsigned LEN1        = 8,
    parameter int unsigned LEN2        = 4,
    parameter int unsigned LEN3        = 10
) (
    input  logic       clk,
    input  logic       rst,
    anim_if.slave      bus,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSE  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] pre_q, pre_d;
    logic [24:0] period;
    logic [3:0]  bcnt_q, bcnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  speed_q, speed_d;
    logic        paused_q, paused_d;
    logic        blank_q, blank_d;
    logic        tick_q, tick_d;
    logic        done_q, done_d;
    logic        tick;

    function automatic logic [3:0] last_frame(input logic [1:0] m);
        case (m)
            2'd0:    return 4'(LEN0 - 1);
            2'd1:    return 4'(LEN1 - 1);
            2'd2:    return 4'(LEN2 - 1);
            default: return 4'(LEN3 - 1);
        endcase
    endfunction

    // A speed change restarts the frame period, so it also swallows a coinciding tick.
    assign period = 25'(BASE_DIV) >> speed_q;
    assign tick   = (state_q != PAUSE) && !bus.speed_pulse
                    && ({1'b0, pre_q} == period - 25'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        bcnt_d  = bcnt_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        speed_d = speed_q;
        tick_d  = tick;
        done_d  = 1'b0;

        if (bus.speed_pulse)      speed_d = speed_q + 2'd1;
        if (bus.speed_pulse)      pre_d = '0;
        else if (state_q != PAUSE) pre_d = tick ? '0 : pre_q + 24'd1;

        case (state_q)
            RUN: begin
                if (tick) begin
                    if (idx_q == last_frame(mode_q)) begin
                        idx_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                if (bus.pause_pulse) state_d = PAUSE;
            end
            PAUSE: begin
                if (bus.pause_pulse) state_d = RUN;
            end
            SWITCH: begin
                if (tick) begin
                    bcnt_d = bcnt_q + 4'd1;
                    if (bcnt_q + 4'd1 == 4'(BLANK_TICKS)) state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        // Mode change overrides everything else this cycle, including a pending pause toggle.
        if (bus.mode_pulse) begin
            state_d = SWITCH;
            mode_d  = mode_q + 2'd1;
            idx_d   = '0;
            pre_d   = '0;
            bcnt_d  = '0;
            tick_d  = 1'b0;
            done_d  = 1'b0;
        end

        paused_d = (state_d == PAUSE);
        blank_d  = (state_d == SWITCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q    <= '0;
            bcnt_q   <= '0;
            idx_q    <= '0;
            mode_q   <= '0;
            speed_q  <= '0;
            paused_q <= 1'b0;
            blank_q  <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            bcnt_q   <= bcnt_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            speed_q  <= speed_d;
            paused_q <= paused_d;
            blank_q  <= blank_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    assign bus.mode       = mode_q;
    assign bus.frame_idx  = idx_q;
    assign bus.speed      = speed_q;
    assign bus.paused     = paused_q;
    assign bus.blank      = blank_q;
    assign bus.frame_tick = tick_q;
    assign bus.cycle_done = done_q;
    assign fsm_state      = state_q;

endmodule
